// File: rtl/security_zoned.sv
// security_zoned: multi-zone intrusion controller with exit/entry delays, alarm timeout and trip latching.
module security_zoned #(
  parameter int NUM_ZONES = 8,
  parameter int KEY_W = 4,
  parameter logic [KEY_W-1:0] ARM_CODE = 4'b0011,
  parameter logic [KEY_W-1:0] DISARM_CODE = 4'b1100,
  parameter int EXIT_DELAY = 20,
  parameter int ENTRY_DELAY = 10,
  parameter int SIREN_TIMEOUT = 100,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ZONES-1:0] sensors,
  input  logic [NUM_ZONES-1:0] zone_bypass,
  input  logic [NUM_ZONES-1:0] instant_zone,
  input  logic [KEY_W-1:0]     keypad,
  input  logic                 key_valid,
  output logic                 alarm_siren,
  output logic                 armed_led,
  output logic                 arm_fault,
  output logic [2:0]           state,
  output logic [NUM_ZONES-1:0] trip_zones
);
  typedef enum logic [2:0] {S_DIS = 3'd0, S_EXIT, S_ARMED, S_ENTRY, S_ALARM, S_SIL} state_e;
  localparam logic [CNT_W-1:0] EXIT_T = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_T = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_T = CNT_W'(SIREN_TIMEOUT - 1);
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_ZONES-1:0] trip_q;
  logic fault_q;
  logic [NUM_ZONES-1:0] active, inst;
  logic arm_k, dis_k;
  assign active = sensors & ~zone_bypass;
  assign inst = active & instant_zone;
  assign arm_k = key_valid && keypad == ARM_CODE;
  assign dis_k = key_valid && keypad == DISARM_CODE;
  // Counter defaults to zero so every transition and every undelayed state restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DIS;
      cnt_q <= '0;
      trip_q <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      cnt_q <= '0;
      if (state_q inside {S_ARMED, S_ENTRY, S_ALARM, S_SIL}) trip_q <= trip_q | active;
      case (state_q)
        S_DIS: if (arm_k) begin
          if (|active) fault_q <= 1'b1;
          else begin
            state_q <= S_EXIT;
            trip_q <= '0;
          end
        end
        S_EXIT: if (dis_k) state_q <= S_DIS;
          else if (cnt_q == EXIT_T) state_q <= S_ARMED;
          else cnt_q <= cnt_q + 1'b1;
        S_ARMED: if (dis_k) state_q <= S_DIS;
          else if (|inst) state_q <= S_ALARM;
          else if (|active) state_q <= S_ENTRY;
        S_ENTRY: if (dis_k) state_q <= S_DIS;
          else if (|inst || cnt_q == ENTRY_T) state_q <= S_ALARM;
          else cnt_q <= cnt_q + 1'b1;
        S_ALARM: if (dis_k) state_q <= S_DIS;
          else if (cnt_q == SIREN_T) state_q <= S_SIL;
          else cnt_q <= cnt_q + 1'b1;
        S_SIL: if (dis_k) state_q <= S_DIS;
          else if (|(active & ~trip_q)) state_q <= S_ALARM;
        default: state_q <= S_DIS;
      endcase
    end
  end
  assign alarm_siren = state_q == S_ALARM;
  assign armed_led = state_q != S_DIS;
  assign arm_fault = fault_q;
  assign state = state_q;
  assign trip_zones = trip_q;
endmodule

// File: doc/security_zoned.md
# security_zoned

Parametrised multi-zone intrusion controller for the security subsystem. Monitors NUM_ZONES sensor inputs with per-zone bypass and instant/delayed classification. Sequences exit delay, armed, entry delay, alarm and siren-timeout phases from keypad codes. Latches which zones tripped and drives the siren plus status outputs for the panel.

## Interface
- NUM_ZONES, 8, number of sensor zones (1..32)
- KEY_W, 4, keypad code width
- ARM_CODE, 4'b0011, code that arms the system
- DISARM_CODE, 4'b1100, code that disarms or silences the system
- EXIT_DELAY, 20, cycles spent in EXIT before ARMED (>=1)
- ENTRY_DELAY, 10, cycles allowed for disarm after a delayed-zone trip (>=1)
- SIREN_TIMEOUT, 100, cycles the siren sounds before auto-silence (>=1)
- CNT_W, 16, delay counter width; must hold max(EXIT_DELAY, ENTRY_DELAY, SIREN_TIMEOUT)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sensors  in  NUM_ZONES  1 = zone open/tripped
- zone_bypass  in  NUM_ZONES  1 = zone ignored in every state
- instant_zone  in  NUM_ZONES  1 = zone skips entry delay
- keypad  in  KEY_W  entered code
- key_valid  in  1  keypad sampled only in cycles where this is 1
- alarm_siren  out  1  siren drive
- armed_led  out  1  high in EXIT, ARMED, ENTRY, ALARM, SILENCED
- arm_fault  out  1  one-cycle pulse: arm refused because a zone is open
- state  out  3  encoded state (DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, SILENCED=5)
- trip_zones  out  NUM_ZONES  latched record of tripped zones

## Operation
- active = sensors & ~zone_bypass; inst = active & instant_zone; arm_k = key_valid & (keypad==ARM_CODE); dis_k = key_valid & (keypad==DISARM_CODE).
- DISARMED: arm_k & active==0 -> EXIT, trip_zones cleared. arm_k & active!=0 -> stay, arm_fault pulses one cycle.
- EXIT: dis_k -> DISARMED. Counter reaches EXIT_DELAY-1 -> ARMED. Sensors ignored (occupant leaving).
- ARMED: dis_k -> DISARMED (priority). inst!=0 -> ALARM. Else active!=0 -> ENTRY.
- ENTRY: dis_k -> DISARMED (priority, including on terminal count cycle). inst!=0 -> ALARM. Counter reaches ENTRY_DELAY-1 -> ALARM.
- ALARM: dis_k -> DISARMED. Counter reaches SIREN_TIMEOUT-1 -> SILENCED.
- SILENCED: dis_k -> DISARMED. New bit in active not already in trip_zones -> ALARM, counter restarts.
- arm_k outside DISARMED and codes other than ARM/DISARM are ignored.
- trip_zones: in ARMED, ENTRY, ALARM and SILENCED, trip_zones |= active each cycle. Holds through DISARMED for readout. Cleared only on DISARMED->EXIT and on reset.
- Counter: single CNT_W counter, zeroed on every state change and whenever the state has no delay. Increments by 1 each cycle in EXIT, ENTRY and ALARM. No wrap: a terminal compare always exits the state first.

## Timing
- Reset values: state=DISARMED, counter=0, trip_zones=0, alarm_siren=0, armed_led=0, arm_fault=0.
- Moore outputs decoded from the state register. alarm_siren=1 exactly while state==ALARM.
- State changes on the clock edge after the qualifying input cycle: 1-cycle input-to-state latency.
- arm_fault is registered and high in the cycle after the refused arm_k.
- Dwell: EXIT lasts exactly EXIT_DELAY cycles, ENTRY at most ENTRY_DELAY cycles, ALARM at most SIREN_TIMEOUT cycles per entry.
- rst asserted in any state returns to DISARMED at the next edge. Overrides dis_k and sensors in the same cycle.
- Inputs are assumed synchronous to clk; no internal synchronisers.

## Test plan
- Arm/exit/disarm: all sensors 0, arm_k -> state=1 for 20 cycles, then 2. armed_led=1 throughout. dis_k -> state=0 next cycle.
- Arm refused: sensors=8'h04, bypass=0, arm_k -> state stays 0, arm_fault=1 for one cycle. Same with bypass=8'h04 -> EXIT.
- Entry delay disarm: armed, delayed zone 1 opens -> ENTRY. dis_k on 10th ENTRY cycle -> DISARMED, siren never asserts, trip_zones=8'h02.
- Entry timeout: armed, zone 1 opens, no code -> ALARM after exactly 10 ENTRY cycles. Siren high 100 cycles, then SILENCED, siren 0.
- Instant zone and re-trigger: instant_zone=8'h80, armed, sensor 7 opens -> ALARM next cycle. After SILENCED, zone 3 opens -> ALARM again, trip_zones=8'h88.
- Reset mid-alarm: in ALARM, assert rst one cycle -> state=0, siren=0, trip_zones=0, counter=0 at next edge.
